// File: rtl/mont_precompute_pkg.sv
// Shared width and state encodings for the Montgomery precompute block.
// Every file that needs BITS or the state constants imports this package.
package mont_precompute_pkg;

  localparam int BITS  = 8;
  localparam int CNT_W = (BITS > 1) ? $clog2(BITS) : 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/mont_precompute_mod_double.sv
// Combinational 2*x mod n for x < n: one doubling, then at most one subtraction of n.
// The doubled value keeps its carry bit, so the compare against n is exact.
import mont_precompute_pkg::*;

module mod_double (
  input  logic [BITS-1:0] x_i,
  input  logic [BITS-1:0] n_i,
  output logic [BITS-1:0] y_o
);

  logic [BITS:0] dbl;
  logic [BITS:0] n_ext;

  assign dbl   = {x_i, 1'b0};
  assign n_ext = {1'b0, n_i};
  assign y_o   = (dbl >= n_ext) ? BITS'(dbl - n_ext) : BITS'(dbl);

endmodule

// File: rtl/mont_precompute.sv
// Bit-serial Montgomery constants: base*R mod N, R mod N and -N^-1 mod R over BITS RUN cycles.
// Results and the finish pulse are registered on leaving DONE, BITS+1 edges after start is taken.
import mont_precompute_pkg::*;

module mont_precompute (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [BITS-1:0] base,
  input  logic [BITS-1:0] N,
  output logic            busy,
  output logic            finish,
  output logic [BITS-1:0] base_mont,
  output logic [BITS-1:0] one_mont,
  output logic [BITS-1:0] N_prime
);

  logic [1:0]       state_q, state_d;
  logic [BITS-1:0]  n_q, n_d;
  logic [BITS-1:0]  xb_q, xb_d;
  logic [BITS-1:0]  xo_q, xo_d;
  logic [BITS:0]    t_q, t_d;
  logic [BITS-1:0]  r_q, r_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [BITS-1:0]  bm_q, bm_d;
  logic [BITS-1:0]  om_q, om_d;
  logic [BITS-1:0]  np_q, np_d;
  logic             fin_q, fin_d;
  logic [BITS-1:0]  xb_dbl, xo_dbl;

  mod_double u_dbl_xb (.x_i(xb_q), .n_i(n_q), .y_o(xb_dbl));
  mod_double u_dbl_xo (.x_i(xo_q), .n_i(n_q), .y_o(xo_dbl));

  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    xb_d    = xb_q;
    xo_d    = xo_q;
    t_d     = t_q;
    r_d     = r_q;
    cnt_d   = cnt_q;
    bm_d    = bm_q;
    om_d    = om_q;
    np_d    = np_q;
    fin_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          n_d     = N;
          xb_d    = base;
          xo_d    = BITS'(1);
          t_d     = (BITS+1)'(1);
          r_d     = '0;
          cnt_d   = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        xb_d = xb_dbl;
        xo_d = xo_dbl;
        // t < N always holds, so t+N stays below 2^(BITS+1)
        if (t_q[0]) begin
          r_d[cnt_q] = 1'b1;
          t_d        = (t_q + {1'b0, n_q}) >> 1;
        end else begin
          t_d = t_q >> 1;
        end
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(BITS-1)) state_d = ST_DONE;
      end
      ST_DONE: begin
        bm_d    = xb_q;
        om_d    = xo_q;
        np_d    = r_q;
        fin_d   = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      n_q     <= '0;
      xb_q    <= '0;
      xo_q    <= '0;
      t_q     <= '0;
      r_q     <= '0;
      cnt_q   <= '0;
      bm_q    <= '0;
      om_q    <= '0;
      np_q    <= '0;
      fin_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      xb_q    <= xb_d;
      xo_q    <= xo_d;
      t_q     <= t_d;
      r_q     <= r_d;
      cnt_q   <= cnt_d;
      bm_q    <= bm_d;
      om_q    <= om_d;
      np_q    <= np_d;
      fin_q   <= fin_d;
    end
  end

  assign busy      = (state_q != ST_IDLE);
  assign finish    = fin_q;
  assign base_mont = bm_q;
  assign one_mont  = om_q;
  assign N_prime   = np_q;

endmodule

// File: tb/tb_mont_precompute.sv
// Directed and randomised checks of mont_precompute with BITS=8.
module tb_mont_precompute;
  import mont_precompute_pkg::*;

  logic            clk = 1'b0;
  logic            rst;
  logic            start;
  logic [BITS-1:0] base;
  logic [BITS-1:0] N;
  logic            busy;
  logic            finish;
  logic [BITS-1:0] base_mont;
  logic [BITS-1:0] one_mont;
  logic [BITS-1:0] N_prime;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  mont_precompute dut (
    .clk(clk), .rst(rst), .start(start), .base(base), .N(N),
    .busy(busy), .finish(finish), .base_mont(base_mont),
    .one_mont(one_mont), .N_prime(N_prime)
  );

  // Called at #1 after a posedge with the DUT idle; returns #1 after the edge that took start.
  task automatic launch(input logic [7:0] n, input logic [7:0] b);
    start = 1'b1;
    N     = n;
    base  = b;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Edges counted from the one that took start; 0 means no finish within 20 edges.
  task automatic wait_fin(output int lat);
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (finish) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; N = 8'd13; base = 8'd5;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %0b want 0", busy); end
    n_tests++; if (finish !== 1'b0) begin n_fail++; $display("FAIL reset_finish got %0b want 0", finish); end
    n_tests++; if ({base_mont, one_mont, N_prime} !== 24'd0) begin
      n_fail++; $display("FAIL reset_outputs got bm=%0d om=%0d np=%0d want 0 0 0", base_mont, one_mont, N_prime);
    end
  endtask

  task automatic test_basic;
    int lat;
    launch(8'd13, 8'd5);
    N = 8'd7; base = 8'd3;
    n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL basic_busy got %0b want 1", busy); end
    wait_fin(lat);
    n_tests++; if (lat != 9) begin n_fail++; $display("FAIL basic_latency got %0d want 9", lat); end
    n_tests++; if (one_mont !== 8'd9) begin n_fail++; $display("FAIL basic_one_mont got %0d want 9", one_mont); end
    n_tests++; if (base_mont !== 8'd6) begin n_fail++; $display("FAIL basic_base_mont got %0d want 6", base_mont); end
    n_tests++; if (N_prime !== 8'd59) begin n_fail++; $display("FAIL basic_n_prime got %0d want 59", N_prime); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL basic_busy_after got %0b want 0", busy); end
    repeat (3) @(posedge clk);
    #1;
    n_tests++; if (finish !== 1'b0) begin n_fail++; $display("FAIL basic_pulse_width got %0b want 0", finish); end
    n_tests++; if ({base_mont, one_mont, N_prime} !== {8'd6, 8'd9, 8'd59}) begin
      n_fail++; $display("FAIL basic_hold got bm=%0d om=%0d np=%0d want 6 9 59", base_mont, one_mont, N_prime);
    end
  endtask

  task automatic test_n255;
    int lat;
    launch(8'd255, 8'd254);
    wait_fin(lat);
    n_tests++; if (lat != 9) begin n_fail++; $display("FAIL n255_latency got %0d want 9", lat); end
    n_tests++; if ({base_mont, one_mont, N_prime} !== {8'd254, 8'd1, 8'd1}) begin
      n_fail++; $display("FAIL n255_values got bm=%0d om=%0d np=%0d want 254 1 1", base_mont, one_mont, N_prime);
    end
  endtask

  task automatic test_base_zero;
    int lat;
    launch(8'd13, 8'd0);
    wait_fin(lat);
    n_tests++; if (lat != 9) begin n_fail++; $display("FAIL base0_latency got %0d want 9", lat); end
    n_tests++; if ({base_mont, one_mont, N_prime} !== {8'd0, 8'd9, 8'd59}) begin
      n_fail++; $display("FAIL base0_values got bm=%0d om=%0d np=%0d want 0 9 59", base_mont, one_mont, N_prime);
    end
  endtask

  task automatic test_start_while_busy;
    int nfin  = 0;
    int first = 0;
    launch(8'd13, 8'd5);
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (finish) begin
        nfin++;
        if (first == 0) first = k;
      end
      if (k == 3) begin start = 1'b1; N = 8'd7; base = 8'd3; end
      if (k == 4) start = 1'b0;
    end
    n_tests++; if (nfin != 1) begin n_fail++; $display("FAIL busy_start_pulses got %0d want 1", nfin); end
    n_tests++; if (first != 9) begin n_fail++; $display("FAIL busy_start_latency got %0d want 9", first); end
    n_tests++; if ({base_mont, one_mont, N_prime} !== {8'd6, 8'd9, 8'd59}) begin
      n_fail++; $display("FAIL busy_start_values got bm=%0d om=%0d np=%0d want 6 9 59", base_mont, one_mont, N_prime);
    end
  endtask

  task automatic test_reset_mid_run;
    int lat;
    launch(8'd13, 8'd5);
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy got %0b want 0", busy); end
    n_tests++; if (finish !== 1'b0) begin n_fail++; $display("FAIL midrst_finish got %0b want 0", finish); end
    n_tests++; if ({base_mont, one_mont, N_prime} !== 24'd0) begin
      n_fail++; $display("FAIL midrst_outputs got bm=%0d om=%0d np=%0d want 0 0 0", base_mont, one_mont, N_prime);
    end
    launch(8'd13, 8'd5);
    wait_fin(lat);
    n_tests++; if (lat != 9) begin n_fail++; $display("FAIL midrst_restart_latency got %0d want 9", lat); end
    n_tests++; if ({base_mont, one_mont, N_prime} !== {8'd6, 8'd9, 8'd59}) begin
      n_fail++; $display("FAIL midrst_restart_values got bm=%0d om=%0d np=%0d want 6 9 59", base_mont, one_mont, N_prime);
    end
  endtask

  task automatic test_random;
    int n, b, lat, exp_om, exp_bm, exp_np;
    for (int run = 0; run < 1000; run++) begin
      n = 2 * $urandom_range(1, 127) + 1;
      b = $urandom_range(0, n - 1);
      exp_om = 256 % n;
      exp_bm = (b * 256) % n;
      exp_np = 0;
      for (int x = 0; x < 256; x++) if (((n * x) % 256) == 255) exp_np = x;
      launch(8'(n), 8'(b));
      wait_fin(lat);
      n_tests++;
      if (lat != 9 || int'(base_mont) != exp_bm || int'(one_mont) != exp_om ||
          int'(N_prime) != exp_np || ((n * int'(N_prime)) % 256) != 255) begin
        n_fail++;
        $display("FAIL random N=%0d base=%0d got lat=%0d bm=%0d om=%0d np=%0d want 9 %0d %0d %0d",
                 n, b, lat, base_mont, one_mont, N_prime, exp_bm, exp_om, exp_np);
      end
    end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_n255;
    test_base_zero;
    test_start_while_busy;
    test_reset_mid_run;
    test_random;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
